// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with per-register busy (reservation)
// bits. Two combinational read ports, two write ports (port 2 wins on an
// address collision), optional hardwired-zero register 0 and optional
// same-cycle write-to-read forwarding.
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we1,
  input  logic [ADDR_W-1:0] w_address1,
  input  logic [DATA_W-1:0] w_data1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] w_address2,
  input  logic [DATA_W-1:0] w_data2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_address,
  input  logic [ADDR_W-1:0] r_address1,
  output logic [DATA_W-1:0] r_data1,
  output logic              r_busy1,
  input  logic [ADDR_W-1:0] r_address2,
  output logic [DATA_W-1:0] r_data2,
  output logic              r_busy2,
  output logic              busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              we1_eff;
  logic              we2_eff;
  logic              rsv_eff;
  logic [DATA_W:0]   rd_port1;
  logic [DATA_W:0]   rd_port2;

  // Requests aimed at a hardwired-zero register 0 are dropped here so that
  // neither the array, the busy bits nor the forwarding path ever see them.
  always_comb begin
    we1_eff = we1 && !((ZERO_REG != 0) && (w_address1 == '0));
    we2_eff = we2 && !((ZERO_REG != 0) && (w_address2 == '0));
    rsv_eff = rsv && !((ZERO_REG != 0) && (rsv_address == '0));
  end

  // Next busy vector: writes retire the old producer, then a reservation
  // installs a new one (so rsv wins over a write to the same register).
  always_comb begin
    busy_nxt = busy;
    if (we1_eff) busy_nxt[w_address1] = 1'b0;
    if (we2_eff) busy_nxt[w_address2] = 1'b0;
    if (rsv_eff) busy_nxt[rsv_address] = 1'b1;
  end

  // Array and busy state: reset, then synchronous clear, then write/reserve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we1_eff) regs[w_address1] <= w_data1;
      if (we2_eff) regs[w_address2] <= w_data2;
      busy <= busy_nxt;
    end
  end

  // One read port: returns {busy, data}. Forwarding is suppressed during a
  // clear, so a clear cycle still shows the pre-clear contents.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic           hit1;
    logic           hit2;
    logic           rsv_hit;
    logic [DATA_W:0] res;
    hit1    = (BYPASS != 0) && !clr && we1_eff && (w_address1 == a);
    hit2    = (BYPASS != 0) && !clr && we2_eff && (w_address2 == a);
    rsv_hit = rsv_eff && (rsv_address == a);
    res     = {busy[a], regs[a]};
    if (hit2)
      res = {rsv_hit, w_data2};
    else if (hit1)
      res = {rsv_hit, w_data1};
    if ((ZERO_REG != 0) && (a == '0))
      res = '0;
    return res;
  endfunction

  // Combinational read ports.
  always_comb begin
    rd_port1 = read_port(r_address1);
    rd_port2 = read_port(r_address2);
  end

  assign r_data1  = rd_port1[DATA_W-1:0];
  assign r_busy1  = rd_port1[DATA_W];
  assign r_data2  = rd_port2[DATA_W-1:0];
  assign r_busy2  = rd_port2[DATA_W];
  assign busy_any = |busy;

endmodule
